// File: rtl/cond_logic_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cond_logic_if
//  Purpose  : Decoder-side bundle for the conditional-execution stage.
//             Carries the condition field, ALU flags and write requests in,
//             and the gated enables, flags and skip count out.
//  Revision : 1.0  initial release
// ============================================================================
interface cond_logic_if;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        RegW;
  logic        MemW;
  logic        InstrValid;
  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  Flags;
  logic [15:0] SkipCount;

  // Decoder side drives requests and observes gated results
  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, InstrValid,
    input  PCSrc, RegWrite, MemWrite, Flags, SkipCount
  );

  // Conditional-execution stage side
  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, InstrValid,
    output PCSrc, RegWrite, MemWrite, Flags, SkipCount
  );
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cond_logic
//  Purpose  : Holds NZCV flags, evaluates the instruction condition field
//             against them, gates PCS/RegW/MemW into architectural write
//             enables and keeps a saturating count of squashed instructions.
//  Options  : CONDEX_REG_EN - register the execute gate for a multicycle
//             datapath (gated outputs lag Cond by one cycle).
//  Revision : 1.0  initial release
// ============================================================================
module cond_logic (
  input  logic         clk,
  input  logic         reset_n,
  cond_logic_if.slave  bus
);

  localparam logic [15:0] SKIP_MAX = 16'hFFFF;

  logic [3:0]  flags_q;
  logic [3:0]  flags_d;
  logic [15:0] skip_q;
  logic [15:0] skip_d;
  logic        condex;
  logic        exec;
  logic        gate;
  logic        n_f;
  logic        z_f;
  logic        c_f;
  logic        v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition check uses the stored flags only, so an instruction never
  // sees the flags it is itself producing.
  always_comb begin
    condex = 1'b0;
    case (bus.Cond)
      4'b0000: condex = z_f;
      4'b0001: condex = ~z_f;
      4'b0010: condex = c_f;
      4'b0011: condex = ~c_f;
      4'b0100: condex = n_f;
      4'b0101: condex = ~n_f;
      4'b0110: condex = v_f;
      4'b0111: condex = ~v_f;
      4'b1000: condex = c_f & ~z_f;
      4'b1001: condex = ~c_f | z_f;
      4'b1010: condex = (n_f == v_f);
      4'b1011: condex = (n_f != v_f);
      4'b1100: condex = ~z_f & (n_f == v_f);
      4'b1101: condex = z_f | (n_f != v_f);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;   // 1111: never executes
    endcase
  end

  assign exec = condex & bus.InstrValid;

  // Next-state for the two independent flag halves and the skip counter
  always_comb begin
    flags_d = flags_q;
    skip_d  = skip_q;
    if (exec && bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (exec && bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    if (bus.InstrValid && !condex && (skip_q != SKIP_MAX)) skip_d = skip_q + 16'd1;
  end

  // Flag and counter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      skip_q  <= 16'h0000;
    end else begin
      flags_q <= flags_d;
      skip_q  <= skip_d;
    end
  end

`ifdef CONDEX_REG_EN
  logic gate_q;

  // Execute gate captured for the next cycle of a multicycle datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gate_q <= 1'b0;
    else          gate_q <= exec;
  end

  assign gate = gate_q;
`else
  // Reset is folded in so the enables drop as soon as reset asserts,
  // even though cleared flags would otherwise let AL pass.
  assign gate = exec & reset_n;
`endif

  assign bus.PCSrc     = bus.PCS  & gate;
  assign bus.RegWrite  = bus.RegW & gate;
  assign bus.MemWrite  = bus.MemW & gate;
  assign bus.Flags     = flags_q;
  assign bus.SkipCount = skip_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cond_logic
//  Purpose  : Self-checking bench for cond_logic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cond_logic;

  logic clk = 1'b0;
  logic reset_n;

  cond_logic_if bus ();

  cond_logic dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [3:0] m_flags;
  int         m_skip;
  logic       m_g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Condition meaning expressed in terms of comparisons
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, eq, uhi, sge;
    {n, z, cy, v} = f;
    eq  = z;
    uhi = cy && !z;
    sge = (n == v);
    case (c)
      4'h0: return eq;
      4'h1: return !eq;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return uhi;
      4'h9: return !uhi;
      4'hA: return sge;
      4'hB: return !sge;
      4'hC: return sge && !eq;
      4'hD: return !(sge && !eq);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic run_cycle();
    logic ce, g_exp;
    @(negedge clk);
    ce = cond_ok(bus.Cond, m_flags);
`ifdef CONDEX_REG_EN
    g_exp = m_g;
`else
    g_exp = ce & bus.InstrValid;
`endif
    check("PCSrc",     {31'd0, bus.PCSrc},    {31'd0, bus.PCS  & g_exp});
    check("RegWrite",  {31'd0, bus.RegWrite}, {31'd0, bus.RegW & g_exp});
    check("MemWrite",  {31'd0, bus.MemWrite}, {31'd0, bus.MemW & g_exp});
    check("Flags",     {28'd0, bus.Flags},    {28'd0, m_flags});
    check("SkipCount", {16'd0, bus.SkipCount}, m_skip);
    @(posedge clk);
    if (bus.InstrValid && ce) begin
      if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
    end
    if (bus.InstrValid && !ce && m_skip < 65535) m_skip++;
    m_g = ce & bus.InstrValid;
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw, input logic valid);
    bus.Cond = c; bus.ALUFlags = a; bus.FlagW = fw;
    bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.InstrValid = valid;
    run_cycle();
  endtask

  initial begin
    int skip_before;
    // Reset with everything requesting a write
    reset_n = 1'b0;
    bus.Cond = 4'hE; bus.ALUFlags = 4'hF; bus.FlagW = 2'b11;
    bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1; bus.InstrValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_PCSrc",    {31'd0, bus.PCSrc},    32'd0);
    check("rst_RegWrite", {31'd0, bus.RegWrite}, 32'd0);
    check("rst_MemWrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rst_Flags",    {28'd0, bus.Flags},    32'd0);
    check("rst_Skip",     {16'd0, bus.SkipCount}, 32'd0);
    m_flags = 4'h0; m_skip = 0; m_g = 1'b0;
    reset_n = 1'b1;
    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);

    // Flag halves update independently
    drive(4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    check("split_hi", {28'd0, bus.Flags}, 32'hC);
    drive(4'hE, 4'h3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("split_lo", {28'd0, bus.Flags}, 32'hF);

    // Full condition x flag sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(4'(c), 4'($urandom), 2'b00, 1'($urandom), 1'b1, 1'($urandom), 1'b1);
      end
    end

    // Failed condition squashes memory write and flag write, counts a skip
    drive(4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    skip_before = m_skip;
    bus.Cond = 4'h1; bus.ALUFlags = 4'hB; bus.FlagW = 2'b11;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b1; bus.InstrValid = 1'b1;
    run_cycle();
    check("ne_flags", {28'd0, bus.Flags}, 32'h4);
    check("ne_skip",  {16'd0, bus.SkipCount}, skip_before + 1);

    // Instruction cannot satisfy its own condition via its own flags
    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(4'h0, 4'h4, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    check("selfref_flags", {28'd0, bus.Flags}, 32'h0);
    drive(4'hE, 4'h4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic including bubbles
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Saturation of the skip counter
    for (int i = 0; i < 65537; i++) begin
      drive(4'hF, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    check("sat_skip", {16'd0, bus.SkipCount}, 32'hFFFF);
    drive(4'hF, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sat_hold", {16'd0, bus.SkipCount}, 32'hFFFF);

    // Bubbles never count
    for (int i = 0; i < 5; i++) drive(4'hF, 4'($urandom), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    bus.Cond = 4'hE; bus.RegW = 1'b1; bus.PCS = 1'b1; bus.MemW = 1'b1; bus.InstrValid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_skip",  {16'd0, bus.SkipCount}, 32'd0);
    check("arst_flags", {28'd0, bus.Flags}, 32'd0);
    check("arst_regw",  {31'd0, bus.RegWrite}, 32'd0);
    m_flags = 4'h0; m_skip = 0; m_g = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage that sits directly downstream of the main/ALU decoder. It holds the NZCV status flags and evaluates each instruction's 4-bit condition field against them. It gates the decoder's PCS/RegW/MemW into the architectural write enables PCSrc/RegWrite/MemWrite. It also counts instructions squashed by a failed condition, for performance debug.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  in  2  from decoder: [1] write N,Z; [0] write C,V.
- PCS  in  1  from decoder: instruction writes PC.
- RegW  in  1  from decoder: instruction writes register file.
- MemW  in  1  from decoder: instruction writes memory.
- InstrValid  in  1  current cycle holds a real instruction (bubble = 0).
- PCSrc  out  1  gated PC-write select.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated memory write enable.
- Flags  out  4  current {N,Z,C,V} register contents.
- SkipCount  out  16  saturating count of condition-failed valid instructions.

## Operation
- CondEx, a combinational function of Cond and the Flags register (never ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111: 0 (treated as never; no side effects).
- FlagWrite[1] = FlagW[1] & CondEx & InstrValid: loads Flags[3:2] from ALUFlags[3:2] at the clock edge.
- FlagWrite[0] = FlagW[0] & CondEx & InstrValid: loads Flags[1:0] from ALUFlags[1:0].
- The two flag halves update independently; an unwritten half holds its value.
- Outputs: PCSrc = PCS & G, RegWrite = RegW & G, MemWrite = MemW & G, where G is the execute gate (see Configuration).
- SkipCount increments by 1 on each edge where InstrValid & !CondEx. It saturates at 0xFFFF and never wraps.

## Timing
- Reset (async assert, any time): Flags=0000, SkipCount=0, registered CondEx=0. Therefore PCSrc/RegWrite/MemWrite=0.
  - Outputs go low immediately on assert, without waiting for a clock edge.
- Reset deassertion is synchronised externally; the first edge after release is a normal cycle.
- Combinational mode: CondEx uses Flags as of the start of the cycle. A flag-setting instruction affects the condition of the next instruction, never its own.
- A flag write and a condition read in the same cycle use the old flags for the condition; the new value is visible on Flags the cycle after the edge.
- InstrValid=0: no flag write, no count, and in combinational mode G=0.
- SkipCount at 0xFFFF with a skip event stays at 0xFFFF. A simultaneous reset wins.

## Configuration
- Macro CONDEX_REG_EN (multicycle datapath support).
- Defined:
  - CondEx & InstrValid is captured into a 1-bit register every edge.
  - G = the registered value, so gated outputs are delayed one cycle relative to Cond.
  - Flag writes and SkipCount still use combinational CondEx in the current cycle.
- Undefined: G = CondEx & InstrValid combinationally (single-cycle datapath). No extra register.

## Test plan
- Reset: hold reset_n=0 with PCS=RegW=MemW=1, Cond=1110 -> all gated outputs 0, Flags=0000, SkipCount=0. Release, InstrValid=1 -> RegWrite=1 in the same cycle (comb) or the next cycle (CONDEX_REG_EN).
- Flag split: FlagW=10, ALUFlags=1111, Cond=1110 -> Flags=1100 after the edge. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Condition sweep: for each of the 16 codes × all 16 flag values, preload Flags via an AL instruction, then apply Cond with RegW=1 -> RegWrite matches the table above. 1111 always gives 0.
- Failed condition: Flags=0100 (Z=1), Cond=0001 NE, FlagW=11, MemW=1 -> MemWrite=0, Flags unchanged, SkipCount +1.
- Self-reference: Flags=0000, Cond=0000 EQ, FlagW=10, ALUFlags=0100 -> no execution and no flag write. Next cycle, AL with ALUFlags=0100 sets Z; the following EQ executes.
- Saturation/bubble: drive 65537 NV instructions -> SkipCount=0xFFFF. InstrValid=0 cycles with Cond=1111 -> count unchanged. Mid-run reset_n pulse -> SkipCount=0 asynchronously.
